// File: rtl/chimera_pkg.sv
// Shared definitions for the memory-island wide guard: AXI wide channel structs,
// DECERR responder state encodings and the island region decode helper.
package chimera_pkg;

   localparam int unsigned WideAddrWidth = 48;
   localparam int unsigned WideIdWidth   = 4;
   localparam int unsigned WideDataWidth = 512;
   localparam int unsigned WideStrbWidth = WideDataWidth / 8;

   localparam logic [1:0] AxiRespOkay   = 2'b00;
   localparam logic [1:0] AxiRespDecErr = 2'b11;

   typedef enum logic [1:0] {W_IDLE, W_DRAIN, W_RESP} err_w_state_e;
   typedef enum logic {R_IDLE, R_BURST} err_r_state_e;

   typedef struct packed {
      logic [WideIdWidth-1:0]   id;
      logic [WideAddrWidth-1:0] addr;
      logic [7:0]               len;
      logic [2:0]               size;
      logic [1:0]               burst;
   } wide_ax_chan_t;

   typedef struct packed {
      logic [WideDataWidth-1:0] data;
      logic [WideStrbWidth-1:0] strb;
      logic                     last;
   } wide_w_chan_t;

   typedef struct packed {
      logic [WideIdWidth-1:0] id;
      logic [1:0]             resp;
   } wide_b_chan_t;

   typedef struct packed {
      logic [WideIdWidth-1:0]   id;
      logic [WideDataWidth-1:0] data;
      logic [1:0]               resp;
      logic                     last;
   } wide_r_chan_t;

   typedef struct packed {
      wide_ax_chan_t aw;
      logic          aw_valid;
      wide_w_chan_t  w;
      logic          w_valid;
      logic          b_ready;
      wide_ax_chan_t ar;
      logic          ar_valid;
      logic          r_ready;
   } wide_req_t;

   typedef struct packed {
      logic         aw_ready;
      logic         ar_ready;
      logic         w_ready;
      logic         b_valid;
      wide_b_chan_t b;
      logic         r_valid;
      wide_r_chan_t r;
   } wide_rsp_t;

   // Half-open interval: region_end itself belongs to the error space.
   function automatic logic addr_in_region(input logic [WideAddrWidth-1:0] addr,
                                           input logic [WideAddrWidth-1:0] region_start,
                                           input logic [WideAddrWidth-1:0] region_end);
      return (addr >= region_start) && (addr < region_end);
   endfunction

endpackage

// File: rtl/chimera_axi_err_slv.sv
// Per-channel DECERR responder: swallows the W burst of an out-of-range write and
// returns a DECERR B, or generates a full DECERR R burst for an out-of-range read.
module chimera_axi_err_slv
   import chimera_pkg::*;
#(
   parameter int unsigned IdWidth = 4
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               aw_load,
   input  logic [IdWidth-1:0] aw_id,
   input  logic               w_valid,
   input  logic               w_last,
   input  logic               b_ready,
   input  logic               ar_load,
   input  logic [IdWidth-1:0] ar_id,
   input  logic [7:0]         ar_len,
   input  logic               r_ready,
   output logic               w_idle,
   output logic               w_ready,
   output logic               b_valid,
   output logic [IdWidth-1:0] b_id,
   output logic               r_idle,
   output logic               r_valid,
   output logic               r_last,
   output logic [IdWidth-1:0] r_id
);

   err_w_state_e w_state_q, w_state_d;
   err_r_state_e r_state_q, r_state_d;
   logic [7:0]   r_len_q, r_beat_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         w_state_q <= W_IDLE;
         r_state_q <= R_IDLE;
         b_id      <= '0;
         r_id      <= '0;
         r_len_q   <= '0;
         r_beat_q  <= '0;
      end else begin
         w_state_q <= w_state_d;
         r_state_q <= r_state_d;
         if (aw_load) begin
            b_id <= aw_id;
         end
         if (ar_load) begin
            r_id     <= ar_id;
            r_len_q  <= ar_len;
            r_beat_q <= '0;
         end else if (r_valid && r_ready) begin
            r_beat_q <= r_beat_q + 8'd1;
         end
      end
   end

   always_comb begin
      w_state_d = w_state_q;
      w_ready   = 1'b0;
      b_valid   = 1'b0;
      unique case (w_state_q)
         W_IDLE: begin
            if (aw_load) begin
               w_state_d = W_DRAIN;
            end
         end
         W_DRAIN: begin
            w_ready = 1'b1;
            if (w_valid && w_last) begin
               w_state_d = W_RESP;
            end
         end
         W_RESP: begin
            b_valid = 1'b1;
            if (b_ready) begin
               w_state_d = W_IDLE;
            end
         end
         default: w_state_d = W_IDLE;
      endcase
   end

   // The beat counter is compared against the latched len to mark the final beat.
   always_comb begin
      r_state_d = r_state_q;
      r_valid   = 1'b0;
      r_last    = 1'b0;
      unique case (r_state_q)
         R_IDLE: begin
            if (ar_load) begin
               r_state_d = R_BURST;
            end
         end
         R_BURST: begin
            r_valid = 1'b1;
            r_last  = (r_beat_q == r_len_q);
            if (r_ready && r_last) begin
               r_state_d = R_IDLE;
            end
         end
         default: r_state_d = R_IDLE;
      endcase
   end

   assign w_idle = (w_state_q == W_IDLE);
   assign r_idle = (r_state_q == R_IDLE);

endmodule

// File: rtl/chimera_memisland_wide_guard.sv
// Address guard in front of the memory-island wide ports: in-region traffic passes
// through untouched, everything else is answered locally with DECERR.
module chimera_memisland_wide_guard
   import chimera_pkg::*;
#(
   parameter int unsigned          NumWideMst  = 2,
   parameter int unsigned          AddrWidth   = 48,
   parameter int unsigned          IdWidth     = 4,
   parameter int unsigned          MaxTxns     = 4,
   parameter logic [AddrWidth-1:0] RegionStart = 48'h4800_0000,
   parameter logic [AddrWidth-1:0] RegionEnd   = 48'h4804_0000,
   parameter type                  axi_wide_req_t = wide_req_t,
   parameter type                  axi_wide_rsp_t = wide_rsp_t
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  axi_wide_req_t         axi_wide_req_i [NumWideMst],
   output axi_wide_rsp_t         axi_wide_rsp_o [NumWideMst],
   output axi_wide_req_t         axi_isl_req_o  [NumWideMst],
   input  axi_wide_rsp_t         axi_isl_rsp_i  [NumWideMst],
   output logic [NumWideMst-1:0] err_o
);

   localparam logic [7:0] CntMax = 8'(MaxTxns);

   for (genvar i = 0; i < NumWideMst; i++) begin : gen_chan
      axi_wide_req_t      mst_req, isl_req;
      axi_wide_rsp_t      mst_rsp, isl_rsp;
      logic [7:0]         w_cnt, w_pend, r_cnt;
      logic               w_sel, r_sel, err_q;
      logic               aw_miss, aw_ok, aw_ready, aw_hs;
      logic               w_route, w_ready, w_hs, w_last_hs, b_valid, b_hs;
      logic               ar_miss, ar_ok, ar_ready, ar_hs;
      logic               r_valid, r_hs, r_dec;
      logic               err_w_idle, err_w_ready, err_b_valid;
      logic               err_r_idle, err_r_valid, err_r_last;
      logic [IdWidth-1:0] err_b_id, err_r_id;

      assign mst_req = axi_wide_req_i[i];
      assign isl_rsp = axi_isl_rsp_i[i];

      // A new AW/AR may only join the current target; switching waits for a drain.
      assign aw_miss  = !addr_in_region(mst_req.aw.addr, RegionStart, RegionEnd);
      assign aw_ok    = !rst_i && (w_cnt < CntMax) && ((w_cnt == 8'd0) || (w_sel == aw_miss))
                        && (!aw_miss || err_w_idle);
      assign aw_ready = aw_ok && (aw_miss || isl_rsp.aw_ready);
      assign aw_hs    = mst_req.aw_valid && aw_ready;

      assign w_route   = !rst_i && (w_pend != 8'd0);
      assign w_ready   = w_route && (w_sel ? err_w_ready : isl_rsp.w_ready);
      assign w_hs      = mst_req.w_valid && w_ready;
      assign w_last_hs = w_hs && mst_req.w.last;
      assign b_valid   = !rst_i && (w_sel ? err_b_valid : isl_rsp.b_valid);
      assign b_hs      = b_valid && mst_req.b_ready;

      assign ar_miss  = !addr_in_region(mst_req.ar.addr, RegionStart, RegionEnd);
      assign ar_ok    = !rst_i && (r_cnt < CntMax) && ((r_cnt == 8'd0) || (r_sel == ar_miss))
                        && (!ar_miss || err_r_idle);
      assign ar_ready = ar_ok && (ar_miss || isl_rsp.ar_ready);
      assign ar_hs    = mst_req.ar_valid && ar_ready;

      assign r_valid = !rst_i && (r_sel ? err_r_valid : isl_rsp.r_valid);
      assign r_hs    = r_valid && mst_req.r_ready;
      assign r_dec   = r_hs && (r_sel ? err_r_last : isl_rsp.r.last);

      chimera_axi_err_slv #(
         .IdWidth (IdWidth)
      ) i_err_slv (
         .clk_i   (clk_i),
         .rst_i   (rst_i),
         .aw_load (aw_hs && aw_miss),
         .aw_id   (mst_req.aw.id),
         .w_valid (mst_req.w_valid && w_route && w_sel),
         .w_last  (mst_req.w.last),
         .b_ready (!rst_i && mst_req.b_ready && w_sel),
         .ar_load (ar_hs && ar_miss),
         .ar_id   (mst_req.ar.id),
         .ar_len  (mst_req.ar.len),
         .r_ready (!rst_i && mst_req.r_ready && r_sel),
         .w_idle  (err_w_idle),
         .w_ready (err_w_ready),
         .b_valid (err_b_valid),
         .b_id    (err_b_id),
         .r_idle  (err_r_idle),
         .r_valid (err_r_valid),
         .r_last  (err_r_last),
         .r_id    (err_r_id)
      );

      always_comb begin
         isl_req          = mst_req;
         isl_req.aw_valid = mst_req.aw_valid && aw_ok && !aw_miss;
         isl_req.w_valid  = mst_req.w_valid && w_route && !w_sel;
         isl_req.b_ready  = !rst_i && mst_req.b_ready && !w_sel;
         isl_req.ar_valid = mst_req.ar_valid && ar_ok && !ar_miss;
         isl_req.r_ready  = !rst_i && mst_req.r_ready && !r_sel;

         mst_rsp          = '0;
         mst_rsp.aw_ready = aw_ready;
         mst_rsp.w_ready  = w_ready;
         mst_rsp.ar_ready = ar_ready;
         mst_rsp.b_valid  = b_valid;
         mst_rsp.r_valid  = r_valid;
         if (w_sel) begin
            mst_rsp.b.id   = err_b_id;
            mst_rsp.b.resp = AxiRespDecErr;
         end else begin
            mst_rsp.b = isl_rsp.b;
         end
         if (r_sel) begin
            mst_rsp.r.id   = err_r_id;
            mst_rsp.r.resp = AxiRespDecErr;
            mst_rsp.r.last = err_r_last;
         end else begin
            mst_rsp.r = isl_rsp.r;
         end
      end

      always_ff @(posedge clk_i) begin
         if (rst_i) begin
            w_cnt  <= '0;
            w_pend <= '0;
            r_cnt  <= '0;
            w_sel  <= 1'b0;
            r_sel  <= 1'b0;
            err_q  <= 1'b0;
         end else begin
            if (aw_hs) begin
               w_sel <= aw_miss;
            end
            if (ar_hs) begin
               r_sel <= ar_miss;
            end
            w_cnt  <= w_cnt + 8'(aw_hs) - 8'(b_hs);
            w_pend <= w_pend + 8'(aw_hs) - 8'(w_last_hs);
            r_cnt  <= r_cnt + 8'(ar_hs) - 8'(r_dec);
            err_q  <= (aw_hs && aw_miss) || (ar_hs && ar_miss);
         end
      end

      assign axi_isl_req_o[i]  = isl_req;
      assign axi_wide_rsp_o[i] = mst_rsp;
      assign err_o[i]          = err_q;
   end

endmodule

// File: tb/tb_chimera_memisland_wide_guard.sv
// Directed bench for the wide guard: a decode vector table plus hand-written
// sequences for pass-through, DECERR bursts, target switching, credit limits and reset.
module tb_chimera_memisland_wide_guard;
   import chimera_pkg::*;

   typedef struct {
      int          ch;
      bit          is_write;
      logic [47:0] addr;
      bit          exp_isl_valid;
      bit          exp_ready;
   } vec_t;

   logic      clk = 1'b0;
   logic      rst = 1'b1;
   wide_req_t req     [2];
   wide_rsp_t rsp     [2];
   wide_req_t isl_req [2];
   wide_rsp_t isl_rsp [2];
   logic [1:0] err;

   int   tests = 0;
   int   fails = 0;
   int   err_cnt    [2];
   int   isl_ar_cnt [2];
   int   base_err, base_ar;
   vec_t vecs [8];

   always #5 clk = ~clk;

   chimera_memisland_wide_guard dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .axi_wide_req_i (req),
      .axi_wide_rsp_o (rsp),
      .axi_isl_req_o  (isl_req),
      .axi_isl_rsp_i  (isl_rsp),
      .err_o          (err)
   );

   // Observers for error pulses and island AR activity outside reset.
   always @(negedge clk) begin
      if (!rst) begin
         for (int c = 0; c < 2; c++) begin
            err_cnt[c]    += int'(err[c]);
            isl_ar_cnt[c] += int'(isl_req[c].ar_valid);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic wide_ax_chan_t make_ax(input int id, input logic [47:0] addr, input int len);
      wide_ax_chan_t a;
      a       = '0;
      a.id    = 4'(id);
      a.addr  = addr;
      a.len   = 8'(len);
      a.size  = 3'd6;
      a.burst = 2'b01;
      return a;
   endfunction

   // Present a single AW or AR, check decode, and withdraw it before the edge.
   task automatic apply_stimulus(input vec_t v);
      if (v.is_write) begin
         req[v.ch].aw       = make_ax(1, v.addr, 0);
         req[v.ch].aw_valid = 1'b1;
      end else begin
         req[v.ch].ar       = make_ax(1, v.addr, 0);
         req[v.ch].ar_valid = 1'b1;
      end
      settle();
      if (v.is_write) begin
         check_output($sformatf("vec aw %0h isl_valid", v.addr), isl_req[v.ch].aw_valid, v.exp_isl_valid);
         check_output($sformatf("vec aw %0h ready", v.addr), rsp[v.ch].aw_ready, v.exp_ready);
      end else begin
         check_output($sformatf("vec ar %0h isl_valid", v.addr), isl_req[v.ch].ar_valid, v.exp_isl_valid);
         check_output($sformatf("vec ar %0h ready", v.addr), rsp[v.ch].ar_ready, v.exp_ready);
      end
      req[v.ch].aw_valid = 1'b0;
      req[v.ch].ar_valid = 1'b0;
      tick();
   endtask

   initial begin
      #200000;
      fails++;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      for (int c = 0; c < 2; c++) begin
         req[c]        = '0;
         isl_rsp[c]    = '0;
         err_cnt[c]    = 0;
         isl_ar_cnt[c] = 0;
      end
      vecs[0] = '{0, 1'b0, 48'h4800_0000, 1'b1, 1'b0};
      vecs[1] = '{1, 1'b0, 48'h4803_FFFF, 1'b1, 1'b0};
      vecs[2] = '{0, 1'b0, 48'h4804_0000, 1'b0, 1'b1};
      vecs[3] = '{1, 1'b0, 48'h47FF_FFFF, 1'b0, 1'b1};
      vecs[4] = '{0, 1'b1, 48'h4802_0000, 1'b1, 1'b0};
      vecs[5] = '{1, 1'b1, 48'h1_4800_0000, 1'b0, 1'b1};
      vecs[6] = '{0, 1'b1, 48'hFFFF_FFFF_FFFF, 1'b0, 1'b1};
      vecs[7] = '{1, 1'b1, 48'h4804_0000, 1'b0, 1'b1};

      // Reset: everything toward both sides must stay quiet even with requests pending.
      req[0].ar          = make_ax(1, 48'h4800_0000, 0);
      req[0].ar_valid    = 1'b1;
      req[0].aw          = make_ax(1, 48'h1000, 0);
      req[0].aw_valid    = 1'b1;
      req[0].r_ready     = 1'b1;
      req[0].b_ready     = 1'b1;
      isl_rsp[0].ar_ready = 1'b1;
      tick();
      tick();
      settle();
      check_output("rst isl_ar_valid", isl_req[0].ar_valid, 1'b0);
      check_output("rst ar_ready", rsp[0].ar_ready, 1'b0);
      check_output("rst aw_ready", rsp[0].aw_ready, 1'b0);
      check_output("rst r_valid", rsp[0].r_valid, 1'b0);
      check_output("rst b_valid", rsp[0].b_valid, 1'b0);
      check_output("rst err", err, 2'b00);
      req[0]     = '0;
      isl_rsp[0] = '0;
      tick();
      rst = 1'b0;
      tick();

      for (int k = 0; k < 8; k++) begin
         apply_stimulus(vecs[k]);
      end

      // Island write: W before AW is held, then AW + 4 beats + B pass through.
      base_err             = err_cnt[0];
      isl_rsp[0].aw_ready  = 1'b1;
      isl_rsp[0].w_ready   = 1'b1;
      req[0].b_ready       = 1'b1;
      req[0].w.data        = 512'h55;
      req[0].w_valid       = 1'b1;
      settle();
      check_output("w_early ready", rsp[0].w_ready, 1'b0);
      check_output("w_early isl_valid", isl_req[0].w_valid, 1'b0);
      tick();
      req[0].aw       = make_ax(6, 48'h4800_0000, 3);
      req[0].aw_valid = 1'b1;
      settle();
      check_output("wr aw isl_valid", isl_req[0].aw_valid, 1'b1);
      check_output("wr aw isl_addr", isl_req[0].aw.addr, 48'h4800_0000);
      check_output("wr aw isl_id", isl_req[0].aw.id, 4'd6);
      check_output("wr aw isl_len", isl_req[0].aw.len, 8'd3);
      check_output("wr aw ready", rsp[0].aw_ready, 1'b1);
      check_output("wr w held in aw cycle", rsp[0].w_ready, 1'b0);
      tick();
      req[0].aw_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         req[0].w.data = {448'h0, 64'hA5A5_0000 + 64'(k)};
         req[0].w.last = (k == 3);
         settle();
         check_output($sformatf("wr beat%0d isl_valid", k), isl_req[0].w_valid, 1'b1);
         check_output($sformatf("wr beat%0d isl_data", k), isl_req[0].w.data[63:0], 64'hA5A5_0000 + 64'(k));
         check_output($sformatf("wr beat%0d isl_last", k), isl_req[0].w.last, (k == 3));
         check_output($sformatf("wr beat%0d ready", k), rsp[0].w_ready, 1'b1);
         tick();
      end
      req[0].w_valid     = 1'b0;
      req[0].w.last      = 1'b0;
      isl_rsp[0].b_valid = 1'b1;
      isl_rsp[0].b.id    = 4'd6;
      isl_rsp[0].b.resp  = AxiRespOkay;
      settle();
      check_output("wr b valid", rsp[0].b_valid, 1'b1);
      check_output("wr b id", rsp[0].b.id, 4'd6);
      check_output("wr b resp", rsp[0].b.resp, AxiRespOkay);
      check_output("wr b isl_ready", isl_req[0].b_ready, 1'b1);
      tick();
      isl_rsp[0] = '0;
      settle();
      check_output("wr err pulses", err_cnt[0] - base_err, 0);
      tick();

      // Out-of-range read: 4 local DECERR beats, one err pulse, nothing toward the island.
      base_err        = err_cnt[0];
      base_ar         = isl_ar_cnt[0];
      req[0].ar       = make_ax(5, 48'h1000, 3);
      req[0].ar_valid = 1'b1;
      req[0].r_ready  = 1'b1;
      settle();
      check_output("derr ar ready", rsp[0].ar_ready, 1'b1);
      check_output("derr ar isl_valid", isl_req[0].ar_valid, 1'b0);
      tick();
      req[0].ar_valid = 1'b0;
      for (int b = 0; b < 4; b++) begin
         settle();
         check_output($sformatf("derr beat%0d valid", b), rsp[0].r_valid, 1'b1);
         check_output($sformatf("derr beat%0d id", b), rsp[0].r.id, 4'd5);
         check_output($sformatf("derr beat%0d resp", b), rsp[0].r.resp, AxiRespDecErr);
         check_output($sformatf("derr beat%0d data_zero", b), (rsp[0].r.data == '0), 1'b1);
         check_output($sformatf("derr beat%0d last", b), rsp[0].r.last, (b == 3));
         tick();
      end
      settle();
      check_output("derr done valid", rsp[0].r_valid, 1'b0);
      check_output("derr err pulses", err_cnt[0] - base_err, 1);
      check_output("derr isl_ar seen", isl_ar_cnt[0] - base_ar, 0);
      tick();

      // Island write outstanding on ch1, then an error AW must wait for the island B.
      base_err            = err_cnt[1];
      isl_rsp[1].aw_ready = 1'b1;
      isl_rsp[1].w_ready  = 1'b1;
      req[1].b_ready      = 1'b1;
      req[1].aw           = make_ax(2, 48'h4801_0000, 0);
      req[1].aw_valid     = 1'b1;
      settle();
      check_output("sw isl aw ready", rsp[1].aw_ready, 1'b1);
      tick();
      req[1].aw_valid = 1'b0;
      req[1].w_valid  = 1'b1;
      req[1].w.last   = 1'b1;
      settle();
      check_output("sw isl w valid", isl_req[1].w_valid, 1'b1);
      tick();
      req[1].w_valid  = 1'b0;
      req[1].aw       = make_ax(9, 48'h100, 1);
      req[1].aw_valid = 1'b1;
      settle();
      check_output("sw stall a", rsp[1].aw_ready, 1'b0);
      tick();
      settle();
      check_output("sw stall b", rsp[1].aw_ready, 1'b0);
      tick();
      isl_rsp[1].b_valid = 1'b1;
      isl_rsp[1].b.id    = 4'd2;
      settle();
      check_output("sw stall at b hs", rsp[1].aw_ready, 1'b0);
      check_output("sw isl b id", rsp[1].b.id, 4'd2);
      tick();
      isl_rsp[1].b_valid = 1'b0;
      settle();
      check_output("sw err aw ready", rsp[1].aw_ready, 1'b1);
      check_output("sw err aw isl_valid", isl_req[1].aw_valid, 1'b0);
      tick();
      req[1].aw_valid = 1'b0;
      req[1].w_valid  = 1'b1;
      req[1].w.last   = 1'b0;
      settle();
      check_output("sw drain0 ready", rsp[1].w_ready, 1'b1);
      check_output("sw drain0 isl_valid", isl_req[1].w_valid, 1'b0);
      tick();
      req[1].w.last = 1'b1;
      settle();
      check_output("sw drain1 ready", rsp[1].w_ready, 1'b1);
      tick();
      req[1].w_valid = 1'b0;
      req[1].w.last  = 1'b0;
      settle();
      check_output("sw derr b valid", rsp[1].b_valid, 1'b1);
      check_output("sw derr b id", rsp[1].b.id, 4'd9);
      check_output("sw derr b resp", rsp[1].b.resp, AxiRespDecErr);
      check_output("sw derr isl b_ready", isl_req[1].b_ready, 1'b0);
      tick();
      settle();
      check_output("sw derr b done", rsp[1].b_valid, 1'b0);
      check_output("sw err pulses", err_cnt[1] - base_err, 1);
      tick();

      // Credit limit: four island ARs fill the counter, the fifth waits for one rlast.
      isl_rsp[0].ar_ready = 1'b1;
      req[0].r_ready      = 1'b1;
      req[0].ar_valid     = 1'b1;
      for (int k = 0; k < 4; k++) begin
         req[0].ar = make_ax(k, 48'h4800_0100, 0);
         settle();
         check_output($sformatf("cred ar%0d ready", k), rsp[0].ar_ready, 1'b1);
         tick();
      end
      req[0].ar = make_ax(4, 48'h4800_0100, 0);
      settle();
      check_output("cred ar4 stall a", rsp[0].ar_ready, 1'b0);
      tick();
      settle();
      check_output("cred ar4 stall b", rsp[0].ar_ready, 1'b0);
      tick();
      isl_rsp[0].r_valid = 1'b1;
      isl_rsp[0].r.last  = 1'b1;
      settle();
      check_output("cred r valid", rsp[0].r_valid, 1'b1);
      check_output("cred stall at rlast", rsp[0].ar_ready, 1'b0);
      tick();
      isl_rsp[0].r_valid = 1'b0;
      settle();
      check_output("cred ar4 resumes", rsp[0].ar_ready, 1'b1);
      tick();
      req[0].ar_valid    = 1'b0;
      isl_rsp[0].r_valid = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
      end
      isl_rsp[0] = '0;

      // Reset in the middle of a DECERR read burst on ch1, then a clean island read.
      req[1].ar       = make_ax(3, 48'h4804_0000, 3);
      req[1].ar_valid = 1'b1;
      req[1].r_ready  = 1'b1;
      settle();
      check_output("rr end ar ready", rsp[1].ar_ready, 1'b1);
      check_output("rr end isl_valid", isl_req[1].ar_valid, 1'b0);
      tick();
      req[1].ar_valid = 1'b0;
      settle();
      check_output("rr beat1 resp", rsp[1].r.resp, AxiRespDecErr);
      check_output("rr beat1 last", rsp[1].r.last, 1'b0);
      tick();
      settle();
      check_output("rr beat2 valid", rsp[1].r_valid, 1'b1);
      check_output("rr beat2 id", rsp[1].r.id, 4'd3);
      rst = 1'b1;
      tick();
      settle();
      check_output("rr after rst valid", rsp[1].r_valid, 1'b0);
      rst = 1'b0;
      tick();
      settle();
      check_output("rr idle valid", rsp[1].r_valid, 1'b0);
      tick();
      isl_rsp[1].ar_ready = 1'b1;
      req[1].ar           = make_ax(1, 48'h4803_FFFF, 0);
      req[1].ar_valid     = 1'b1;
      settle();
      check_output("rr new isl_valid", isl_req[1].ar_valid, 1'b1);
      check_output("rr new isl_addr", isl_req[1].ar.addr, 48'h4803_FFFF);
      check_output("rr new ar ready", rsp[1].ar_ready, 1'b1);
      tick();
      req[1].ar_valid    = 1'b0;
      isl_rsp[1].r_valid = 1'b1;
      isl_rsp[1].r.id    = 4'd1;
      isl_rsp[1].r.resp  = AxiRespOkay;
      isl_rsp[1].r.last  = 1'b1;
      isl_rsp[1].r.data  = 512'h77;
      settle();
      check_output("rr new r valid", rsp[1].r_valid, 1'b1);
      check_output("rr new r id", rsp[1].r.id, 4'd1);
      check_output("rr new r resp", rsp[1].r.resp, AxiRespOkay);
      check_output("rr new r data", rsp[1].r.data[63:0], 64'h77);
      check_output("rr new isl r_ready", isl_req[1].r_ready, 1'b1);
      tick();
      isl_rsp[1] = '0;
      tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
